// File: rtl/ondra_video_dma_ctrl.sv
// Video DMA sequencer: requests the Z80 bus per frame, issues one VRAM byte fetch
// per 8-clock slot on each visible microline, and releases the bus at frame end or abort.
module ondra_video_dma_ctrl #(
    parameter int BYTES_PER_LINE = 40,
    parameter int VIS_LINES      = 255
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       video_en,
    input  logic       vsync_n,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic       slot_tick,
    input  logic       busak_n,
    output logic       busrq_n,
    output logic       fetch_load,
    output logic [5:0] vram_col,
    output logic [7:0] vram_row,
    output logic       dma_active,
    output logic       frame_done,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ARMED,
        FETCH,
        RELEASE
    } state_t;

    localparam logic [5:0] COL_LAST = 6'(BYTES_PER_LINE - 1);
    localparam logic [7:0] ROW_END  = 8'(VIS_LINES);

    state_t     state, state_nx;
    logic       busrq_nx, load_nx, active_nx, done_nx, overrun_nx;
    logic [5:0] col_nx;
    logic [7:0] row_nx;
    logic [7:0] row_inc;
    logic       abort;

    assign abort   = ~video_en | ~vsync_n;
    assign row_inc = vram_row + 8'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx   = state;
        busrq_nx   = busrq_n;
        load_nx    = 1'b0;
        col_nx     = vram_col;
        row_nx     = vram_row;
        active_nx  = dma_active;
        done_nx    = 1'b0;
        overrun_nx = overrun;

        case (state)
            IDLE: begin
                if (frame_start && !abort) begin
                    state_nx = REQ;
                    busrq_nx = 1'b0;
                end
            end
            REQ: begin
                if (!busak_n) begin
                    state_nx  = ARMED;
                    active_nx = 1'b1;
                end
            end
            ARMED: begin
                // A slot_tick coinciding with line_start is deliberately skipped.
                if (line_start) begin
                    state_nx = FETCH;
                    col_nx   = '0;
                end
            end
            FETCH: begin
                if (line_start) begin
                    // Line restarted before it finished: drop the partial line and move on.
                    overrun_nx = 1'b1;
                    row_nx     = row_inc;
                    col_nx     = '0;
                    if (row_inc == ROW_END) state_nx = RELEASE;
                end else if (fetch_load) begin
                    // Column/row advance the cycle after the load pulse they described.
                    if (vram_col == COL_LAST) begin
                        row_nx   = row_inc;
                        state_nx = (row_inc == ROW_END) ? RELEASE : ARMED;
                    end else begin
                        col_nx = vram_col + 6'd1;
                    end
                end else if (slot_tick) begin
                    load_nx = 1'b1;
                end
            end
            RELEASE: begin
                if (busak_n) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    row_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (abort && (state == REQ || state == ARMED || state == FETCH)) begin
            state_nx = RELEASE;
            load_nx  = 1'b0;
        end

        if (state_nx == RELEASE) begin
            busrq_nx  = 1'b1;
            active_nx = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busrq_n    <= 1'b1;
            fetch_load <= 1'b0;
            vram_col   <= '0;
            vram_row   <= '0;
            dma_active <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= state_nx;
            busrq_n    <= busrq_nx;
            fetch_load <= load_nx;
            vram_col   <= col_nx;
            vram_row   <= row_nx;
            dma_active <= active_nx;
            frame_done <= done_nx;
            overrun    <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_ondra_video_dma_ctrl.sv
// Scoreboard bench for ondra_video_dma_ctrl: stimulus pushes expected fetches, a
// negedge monitor pops and compares each fetch_load against the frame model.
module tb_ondra_video_dma_ctrl;

    localparam int BPL = 4;
    localparam int VIS = 2;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       video_en = 1'b1;
    logic       vsync_n = 1'b1;
    logic       frame_start = 1'b0;
    logic       line_start = 1'b0;
    logic       slot_tick = 1'b0;
    logic       busak_n = 1'b1;
    logic       busrq_n, fetch_load, dma_active, frame_done, overrun;
    logic [5:0] vram_col;
    logic [7:0] vram_row;

    ondra_video_dma_ctrl #(.BYTES_PER_LINE(BPL), .VIS_LINES(VIS)) dut (
        .clk_sys(clk_sys), .reset(reset), .video_en(video_en), .vsync_n(vsync_n),
        .frame_start(frame_start), .line_start(line_start), .slot_tick(slot_tick),
        .busak_n(busak_n), .busrq_n(busrq_n), .fetch_load(fetch_load),
        .vram_col(vram_col), .vram_row(vram_row), .dma_active(dma_active),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int col;
        int row;
    } fetch_t;

    fetch_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    int div = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every fetch_load pulse is matched against the next expected fetch.
    always @(negedge clk_sys) begin : monitor
        fetch_t e;
        if (!reset) begin
            if (frame_done) done_cnt++;
            if (fetch_load) begin
                load_cnt++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_load: got load col %0d row %0d, expected none", vram_col, vram_row);
                end else begin
                    e = exp_q.pop_front();
                    check("load_col", 32'(vram_col), e.col);
                    check("load_row", 32'(vram_row), e.row);
                    check("load_busrq_n", 32'(busrq_n), 0);
                    check("load_active", 32'(dma_active), 1);
                end
            end
        end
    end

    // One clock: inputs change 1 time unit after the rising edge; slot_tick every 8 clocks.
    task automatic step(input bit ls);
        @(posedge clk_sys);
        #1;
        div         = (div + 1) % 8;
        slot_tick   = (div == 7);
        line_start  = ls;
        frame_start = 1'b0;
    endtask

    task automatic wait_loads(input int target, input string name);
        int n = 0;
        while (load_cnt < target && n < 200) begin
            step(0);
            n++;
        end
        check(name, load_cnt, target);
    endtask

    // Reference model: a frame is rows 0..VIS-1, each BPL bytes, except a row
    // cut short by overrun (ovr_k bytes) or an abort during row 0 (abort_k bytes).
    task automatic push_frame(input int ovr_row, input int ovr_k, input int abort_k);
        fetch_t f;
        for (int r = 0; r < VIS; r++) begin
            int n;
            n = (r == ovr_row) ? ovr_k : BPL;
            if (abort_k >= 0) n = (r == 0) ? abort_k : 0;
            for (int c = 0; c < n; c++) begin
                f.col = c;
                f.row = r;
                exp_q.push_back(f);
            end
        end
    endtask

    task automatic start_frame(input int grant_delay);
        int base;
        base = load_cnt;
        frame_start = 1'b1;
        check("busrq_before_req", 32'(busrq_n), 1);
        step(0);
        check("busrq_req_latency", 32'(busrq_n), 0);
        repeat (grant_delay) step(0);
        check("busrq_held_no_grant", 32'(busrq_n), 0);
        check("no_load_before_grant", load_cnt, base);
        check("inactive_before_grant", 32'(dma_active), 0);
        busak_n = 1'b0;
        step(0);
        check("active_on_grant", 32'(dma_active), 1);
        frame_start = 1'b1;
        step(0);
        check("frame_start_ignored", 32'(busrq_n), 0);
    endtask

    task automatic finish_frame();
        int n, d0;
        n = 0;
        while (busrq_n !== 1'b1 && n < 20) begin
            step(0);
            n++;
        end
        check("busrq_released", 32'(busrq_n), 1);
        check("inactive_released", 32'(dma_active), 0);
        check("scoreboard_drained", exp_q.size(), 0);
        d0 = done_cnt;
        repeat ($urandom_range(1, 5)) step(0);
        check("no_done_while_busak", done_cnt, d0);
        busak_n = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            step(0);
            n++;
        end
        repeat (2) step(0);
        check("frame_done_once", done_cnt, d0 + 1);
        check("row_cleared", 32'(vram_row), 0);
    endtask

    task automatic run_frame(input int grant_delay, input int ovr_row, input int ovr_k, input bit coincide);
        bit started;
        int base;
        push_frame(ovr_row, ovr_k, -1);
        start_frame(grant_delay);
        started = 1'b0;
        for (int r = 0; r < VIS; r++) begin
            base = load_cnt;
            if (!started && r == 0 && coincide) begin
                while (div != 6) step(0);
                step(1);
                repeat (8) step(0);
                check("coincide_slot_skipped", load_cnt, base);
                step(0);
                check("coincide_first_load", 32'(fetch_load), 1);
                check("coincide_first_col", 32'(vram_col), 0);
            end else if (!started) begin
                repeat ($urandom_range(0, 9)) step(0);
                step(1);
            end
            started = 1'b0;
            if (r == ovr_row) begin
                wait_loads(base + ovr_k, "partial_line_loads");
                step(1);
                step(0);
                check("overrun_set", 32'(overrun), 1);
                check("overrun_row", 32'(vram_row), r + 1);
                check("overrun_col", 32'(vram_col), 0);
                started = 1'b1;
            end else begin
                wait_loads(base + BPL, "full_line_loads");
            end
        end
        finish_frame();
    endtask

    task automatic abort_frame(input int k, input bit use_vsync);
        int base;
        push_frame(-1, 0, k);
        start_frame(3);
        base = load_cnt;
        step(1);
        wait_loads(base + k, "loads_before_abort");
        if (use_vsync) vsync_n = 1'b0;
        else video_en = 1'b0;
        step(0);
        check("abort_busrq", 32'(busrq_n), 1);
        check("abort_inactive", 32'(dma_active), 0);
        repeat (30) step(0);
        check("no_load_after_abort", load_cnt, base + k);
        finish_frame();
        video_en = 1'b1;
        vsync_n  = 1'b1;
        step(0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step(0);
        check("rst_busrq", 32'(busrq_n), 1);
        check("rst_load", 32'(fetch_load), 0);
        check("rst_col", 32'(vram_col), 0);
        check("rst_row", 32'(vram_row), 0);
        check("rst_active", 32'(dma_active), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        step(0);

        // frame_start while inhibited is not accepted.
        video_en = 1'b0;
        frame_start = 1'b1;
        step(0);
        step(0);
        check("inhibit_no_req", 32'(busrq_n), 1);
        video_en = 1'b1;
        step(0);

        run_frame(3, -1, 0, 1'b0);
        check("no_overrun_clean", 32'(overrun), 0);
        run_frame(100, -1, 0, 1'b0);
        abort_frame(2, 1'b0);
        abort_frame(1, 1'b1);
        run_frame(4, 0, 2, 1'b0);
        run_frame(2, -1, 0, 1'b1);

        // Asynchronous reset in the middle of a fetch line.
        push_frame(-1, 0, -1);
        start_frame(2);
        step(1);
        wait_loads(load_cnt + 1, "loads_before_reset");
        #2 reset = 1'b1;
        #1;
        check("async_busrq", 32'(busrq_n), 1);
        check("async_load", 32'(fetch_load), 0);
        check("async_col", 32'(vram_col), 0);
        check("async_row", 32'(vram_row), 0);
        check("async_active", 32'(dma_active), 0);
        check("async_overrun", 32'(overrun), 0);
        exp_q.delete();
        busak_n = 1'b1;
        repeat (3) step(0);
        reset = 1'b0;
        step(0);
        run_frame(3, -1, 0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            int orow;
            orow = $urandom_range(0, 3);
            if (orow >= VIS) orow = -1;
            run_frame($urandom_range(0, 20), orow, $urandom_range(1, BPL - 1), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
